// File: rtl/id_stage_fwd_if.sv
// ID-stage handshake bundle: IF/ID side (instruction in, id_ready out),
// flush/ex_ready control, and the registered ID/EX fields toward EX.
// The slave modport is the ID stage; the master modport is its environment.
interface id_stage_fwd_if #(
  parameter int DW  = 32,
  parameter int RA  = 5,
  parameter int OPW = 8
);
  logic           id_valid;
  logic [DW-1:0]  id_pc;
  logic [31:0]    id_ins;
  logic           id_ready;
  logic           flush;
  logic           ex_ready;

  logic           ex_valid;
  logic [DW-1:0]  ex_pc;
  logic [OPW-1:0] ex_alu_op;
  logic [2:0]     ex_alu_sel;
  logic [DW-1:0]  ex_src1;
  logic [DW-1:0]  ex_src2;
  logic           ex_wr_en;
  logic [RA-1:0]  ex_wr_addr;
  logic           ex_illegal;

  modport slave (
    input  id_valid, id_pc, id_ins, flush, ex_ready,
    output id_ready,
    output ex_valid, ex_pc, ex_alu_op, ex_alu_sel, ex_src1, ex_src2,
           ex_wr_en, ex_wr_addr, ex_illegal
  );

  modport master (
    output id_valid, id_pc, id_ins, flush, ex_ready,
    input  id_ready,
    input  ex_valid, ex_pc, ex_alu_op, ex_alu_sel, ex_src1, ex_src2,
           ex_wr_en, ex_wr_addr, ex_illegal
  );
endinterface

// File: rtl/id_stage_fwd.sv
// Registered instruction-decode stage for the logic/immediate/shift subset.
// Reads the register file, resolves operands through NUM_FWD prioritised
// forwarding sources (index 0 youngest), stalls on load-use and holds the
// result in an ID/EX register with valid/ready handshake and flush.
// Optional build macro ID_STALL_CNT_EN adds o_stall_cnt, a saturating count
// of cycles in which a valid instruction was held back in ID.
module id_stage_fwd #(
  parameter int DW      = 32,
  parameter int RA      = 5,
  parameter int NUM_FWD = 2,
  parameter int OPW     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  id_stage_fwd_if.slave         bus,
  output logic                  o_rf_rd1_en,
  output logic [RA-1:0]         o_rf_addr1,
  output logic                  o_rf_rd2_en,
  output logic [RA-1:0]         o_rf_addr2,
  input  logic [DW-1:0]         i_rf_data1,
  input  logic [DW-1:0]         i_rf_data2,
  input  logic [NUM_FWD-1:0]    i_fwd_en,
  input  logic [NUM_FWD*RA-1:0] i_fwd_addr,
  input  logic [NUM_FWD*DW-1:0] i_fwd_data,
  input  logic                  i_ex_is_load,
  input  logic [RA-1:0]         i_ex_ld_addr
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]           o_stall_cnt
`endif
);

  logic [5:0]     w_opcode;
  logic [5:0]     w_funct;
  logic [4:0]     w_shamt;
  logic [15:0]    w_imm;
  logic [RA-1:0]  w_rs;
  logic [RA-1:0]  w_rt;
  logic [RA-1:0]  w_rd;

  logic           w_rd1_en;
  logic           w_rd2_en;
  logic           w_illegal;
  logic           w_wr;
  logic           w_wr_en;
  logic [RA-1:0]  w_dst;
  logic [OPW-1:0] w_op;
  logic [2:0]     w_sel;
  logic [DW-1:0]  w_imm1;
  logic [DW-1:0]  w_imm2;
  logic [DW-1:0]  w_fwd1;
  logic [DW-1:0]  w_fwd2;
  logic [DW-1:0]  w_src1;
  logic [DW-1:0]  w_src2;
  logic           w_hazard;
  logic           w_id_ready;

  logic           r_ex_valid;
  logic [DW-1:0]  r_ex_pc;
  logic [OPW-1:0] r_ex_alu_op;
  logic [2:0]     r_ex_alu_sel;
  logic [DW-1:0]  r_ex_src1;
  logic [DW-1:0]  r_ex_src2;
  logic           r_ex_wr_en;
  logic [RA-1:0]  r_ex_wr_addr;
  logic           r_ex_illegal;

  assign w_opcode = bus.id_ins[31:26];
  assign w_rs     = RA'(bus.id_ins[25:21]);
  assign w_rt     = RA'(bus.id_ins[20:16]);
  assign w_rd     = RA'(bus.id_ins[15:11]);
  assign w_shamt  = bus.id_ins[10:6];
  assign w_funct  = bus.id_ins[5:0];
  assign w_imm    = bus.id_ins[15:0];

  // Instruction decode: read ports, ALU op/select, destination and immediates.
  // Illegal encodings read nothing and carry zero operands.
  always_comb begin
    w_rd1_en  = 1'b0;
    w_rd2_en  = 1'b0;
    w_illegal = 1'b0;
    w_wr      = 1'b0;
    w_dst     = '0;
    w_op      = '0;
    w_sel     = 3'b000;
    w_imm1    = '0;
    w_imm2    = '0;
    case (w_opcode)
      6'h0D, 6'h0C, 6'h0E: begin
        w_rd1_en = 1'b1;
        w_imm2   = DW'(w_imm);
        w_dst    = w_rt;
        w_wr     = 1'b1;
        w_sel    = 3'b001;
        case (w_opcode)
          6'h0C:   w_op = OPW'(8'h24);
          6'h0E:   w_op = OPW'(8'h26);
          default: w_op = OPW'(8'h25);
        endcase
      end
      6'h0F: begin
        w_rd1_en = 1'b1;
        w_imm2   = DW'({w_imm, 16'h0000});
        w_dst    = w_rt;
        w_wr     = 1'b1;
        w_sel    = 3'b001;
        w_op     = OPW'(8'h25);
      end
      6'h00: begin
        case (w_funct)
          6'h24, 6'h25, 6'h26, 6'h27: begin
            w_rd1_en = 1'b1;
            w_rd2_en = 1'b1;
            w_dst    = w_rd;
            w_wr     = 1'b1;
            w_sel    = 3'b001;
            w_op     = OPW'(w_funct);
          end
          6'h00, 6'h02, 6'h03: begin
            w_rd2_en = 1'b1;
            w_imm1   = DW'(w_shamt);
            w_dst    = w_rd;
            w_wr     = 1'b1;
            w_sel    = 3'b010;
            // funct 0 would collide with the "no op" encoding, so SLL gets its own code
            w_op     = (w_funct == 6'h00) ? OPW'(8'h7C) : OPW'(w_funct);
          end
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_wr_en = w_wr & (w_dst != '0);

  // Forwarding for port 1: scan from oldest to youngest so the lowest index wins.
  always_comb begin
    w_fwd1 = i_rf_data1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_en[i] && (i_fwd_addr[i*RA +: RA] == w_rs))
        w_fwd1 = i_fwd_data[i*DW +: DW];
    end
  end

  // Forwarding for port 2, same priority as port 1.
  always_comb begin
    w_fwd2 = i_rf_data2;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_en[i] && (i_fwd_addr[i*RA +: RA] == w_rt))
        w_fwd2 = i_fwd_data[i*DW +: DW];
    end
  end

  // r0 reads are hard zero even if some source claims to write r0.
  assign w_src1 = !w_rd1_en ? w_imm1 : ((w_rs == '0) ? '0 : w_fwd1);
  assign w_src2 = !w_rd2_en ? w_imm2 : ((w_rt == '0) ? '0 : w_fwd2);

  assign w_hazard = bus.id_valid & i_ex_is_load & (i_ex_ld_addr != '0) &
                    ((w_rd1_en & (w_rs == i_ex_ld_addr)) |
                     (w_rd2_en & (w_rt == i_ex_ld_addr)));

  assign w_id_ready   = bus.flush | (bus.ex_ready & ~w_hazard);
  assign bus.id_ready = w_id_ready;

  assign o_rf_rd1_en = w_rd1_en;
  assign o_rf_addr1  = w_rs;
  assign o_rf_rd2_en = w_rd2_en;
  assign o_rf_addr2  = w_rt;

  // ID/EX register: reset > flush > hold on backpressure > bubble > load.
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.flush ||
        (bus.ex_ready && (w_hazard || !bus.id_valid))) begin
      r_ex_valid   <= 1'b0;
      r_ex_pc      <= '0;
      r_ex_alu_op  <= '0;
      r_ex_alu_sel <= 3'b000;
      r_ex_src1    <= '0;
      r_ex_src2    <= '0;
      r_ex_wr_en   <= 1'b0;
      r_ex_wr_addr <= '0;
      r_ex_illegal <= 1'b0;
    end else if (bus.ex_ready) begin
      r_ex_valid   <= 1'b1;
      r_ex_pc      <= bus.id_pc;
      r_ex_alu_op  <= w_op;
      r_ex_alu_sel <= w_sel;
      r_ex_src1    <= w_src1;
      r_ex_src2    <= w_src2;
      r_ex_wr_en   <= w_wr_en;
      r_ex_wr_addr <= w_dst;
      r_ex_illegal <= w_illegal;
    end
  end

  assign bus.ex_valid   = r_ex_valid;
  assign bus.ex_pc      = r_ex_pc;
  assign bus.ex_alu_op  = r_ex_alu_op;
  assign bus.ex_alu_sel = r_ex_alu_sel;
  assign bus.ex_src1    = r_ex_src1;
  assign bus.ex_src2    = r_ex_src2;
  assign bus.ex_wr_en   = r_ex_wr_en;
  assign bus.ex_wr_addr = r_ex_wr_addr;
  assign bus.ex_illegal = r_ex_illegal;

`ifdef ID_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count cycles a valid instruction stays in ID; saturate instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_stall_cnt <= '0;
    else if (bus.id_valid && !w_id_ready && !bus.flush && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: decode, forwarding priority, r0 handling,
// load-use stall, backpressure hold, flush, illegal opcode and r0 destination.
module tb_id_stage_fwd;
  localparam int DW = 32, RA = 5, NUM_FWD = 2, OPW = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  rf_rd1_en, rf_rd2_en;
  logic [RA-1:0]         rf_addr1, rf_addr2;
  logic [DW-1:0]         rf_data1, rf_data2;
  logic [NUM_FWD-1:0]    fwd_en;
  logic [NUM_FWD*RA-1:0] fwd_addr;
  logic [NUM_FWD*DW-1:0] fwd_data;
  logic                  ex_is_load;
  logic [RA-1:0]         ex_ld_addr;
`ifdef ID_STALL_CNT_EN
  logic [31:0]           stall_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  id_stage_fwd_if #(.DW(DW), .RA(RA), .OPW(OPW)) bus ();

  id_stage_fwd #(.DW(DW), .RA(RA), .NUM_FWD(NUM_FWD), .OPW(OPW)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .bus          (bus.slave),
    .o_rf_rd1_en  (rf_rd1_en),
    .o_rf_addr1   (rf_addr1),
    .o_rf_rd2_en  (rf_rd2_en),
    .o_rf_addr2   (rf_addr2),
    .i_rf_data1   (rf_data1),
    .i_rf_data2   (rf_data2),
    .i_fwd_en     (fwd_en),
    .i_fwd_addr   (fwd_addr),
    .i_fwd_data   (fwd_data),
    .i_ex_is_load (ex_is_load),
    .i_ex_ld_addr (ex_ld_addr)
`ifdef ID_STALL_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Compare one observed value against the hand-computed expectation.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ex(input string tag, input logic v, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [7:0] op,
                        input logic [2:0] sel, input logic we, input logic [4:0] wa,
                        input logic ill);
    check({tag, ".valid"},   64'(bus.ex_valid),   64'(v));
    check({tag, ".src1"},    64'(bus.ex_src1),    64'(s1));
    check({tag, ".src2"},    64'(bus.ex_src2),    64'(s2));
    check({tag, ".op"},      64'(bus.ex_alu_op),  64'(op));
    check({tag, ".sel"},     64'(bus.ex_alu_sel), 64'(sel));
    check({tag, ".wr_en"},   64'(bus.ex_wr_en),   64'(we));
    check({tag, ".wr_addr"}, 64'(bus.ex_wr_addr), 64'(wa));
    check({tag, ".illegal"}, 64'(bus.ex_illegal), 64'(ill));
  endtask

  initial begin
    reset = 1'b1;
    bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_ins = '0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1;
    rf_data1 = '0; rf_data2 = '0;
    fwd_en = '0; fwd_addr = '0; fwd_data = '0;
    ex_is_load = 1'b0; ex_ld_addr = '0;
    step(); step();
    reset = 1'b0;
    chk_ex("reset", 1'b0, 32'h0, 32'h0, 8'h00, 3'b000, 1'b0, 5'd0, 1'b0);
    check("reset.pc", 64'(bus.ex_pc), 64'h0);

    // ORI r2,r1,0xFFFF
    bus.id_valid = 1'b1; bus.id_pc = 32'h100; bus.id_ins = 32'h3422FFFF;
    rf_data1 = 32'h12340000; rf_data2 = 32'hDEAD0000;
    #1;
    check("ori.rd1_en", 64'(rf_rd1_en), 64'h1);
    check("ori.rd2_en", 64'(rf_rd2_en), 64'h0);
    check("ori.addr1",  64'(rf_addr1),  64'h1);
    check("ori.ready",  64'(bus.id_ready), 64'h1);
    step();
    chk_ex("ori", 1'b1, 32'h12340000, 32'h0000FFFF, 8'h25, 3'b001, 1'b1, 5'd2, 1'b0);
    check("ori.pc", 64'(bus.ex_pc), 64'h100);

    // OR r4,r1,r1 with both sources matching: source 0 wins
    bus.id_pc = 32'h104; bus.id_ins = 32'h00212025;
    fwd_en = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'hB, 32'hA};
    step();
    chk_ex("fwd_pri", 1'b1, 32'hA, 32'hA, 8'h25, 3'b001, 1'b1, 5'd4, 1'b0);

    // only source 1 matches
    fwd_en = 2'b10;
    step();
    check("fwd1.src1", 64'(bus.ex_src1), 64'hB);
    check("fwd1.src2", 64'(bus.ex_src2), 64'hB);

    // OR r4,r0,r0 with a source claiming r0
    bus.id_ins = 32'h00002025; rf_data1 = 32'h77; rf_data2 = 32'h77;
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd0}; fwd_data = {32'h0, 32'h55};
    step();
    check("r0.src1", 64'(bus.ex_src1), 64'h0);
    check("r0.src2", 64'(bus.ex_src2), 64'h0);
    fwd_en = '0;

    // load-use: OR r4,r3,r5 while EX loads r3
    bus.id_pc = 32'h200; bus.id_ins = 32'h00652025;
    rf_data1 = 32'h30; rf_data2 = 32'h50;
    ex_is_load = 1'b1; ex_ld_addr = 5'd3;
    #1;
    check("lu.ready", 64'(bus.id_ready), 64'h0);
    step();
    check("lu.bubble", 64'(bus.ex_valid), 64'h0);
    step(); step(); step();
    check("lu.bubble4", 64'(bus.ex_valid), 64'h0);
`ifdef ID_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'd4);
`endif
    ex_is_load = 1'b0;
    #1;
    check("lu.release", 64'(bus.id_ready), 64'h1);
    step();
    chk_ex("lu.issue", 1'b1, 32'h30, 32'h50, 8'h25, 3'b001, 1'b1, 5'd4, 1'b0);
    check("lu.pc", 64'(bus.ex_pc), 64'h200);

    // backpressure: new instruction presented but EX not ready for 3 cycles
    bus.ex_ready = 1'b0; bus.id_ins = 32'h3001FFFF; rf_data1 = 32'h99;
    step(); step(); step();
    chk_ex("hold", 1'b1, 32'h30, 32'h50, 8'h25, 3'b001, 1'b1, 5'd4, 1'b0);
    bus.flush = 1'b1;
    #1;
    check("flush.ready", 64'(bus.id_ready), 64'h1);
    step();
    check("flush.valid", 64'(bus.ex_valid), 64'h0);
    check("flush.wr_en", 64'(bus.ex_wr_en), 64'h0);
    bus.flush = 1'b0; bus.ex_ready = 1'b1;

    // illegal opcode 0x3F
    bus.id_ins = 32'hFC000000;
    #1;
    check("ill.rd1_en", 64'(rf_rd1_en), 64'h0);
    step();
    chk_ex("illegal", 1'b1, 32'h0, 32'h0, 8'h00, 3'b000, 1'b0, 5'd0, 1'b1);

    // ORI r0,r1,0x1234: legal but no write
    bus.id_ins = 32'h34201234; rf_data1 = 32'h1;
    step();
    chk_ex("ori_r0", 1'b1, 32'h1, 32'h1234, 8'h25, 3'b001, 1'b0, 5'd0, 1'b0);

    // SRA r6,r2,5
    bus.id_ins = 32'h00023143; rf_data2 = 32'hF0;
    #1;
    check("sra.rd1_en", 64'(rf_rd1_en), 64'h0);
    step();
    chk_ex("sra", 1'b1, 32'h5, 32'hF0, 8'h03, 3'b010, 1'b1, 5'd6, 1'b0);

    // LUI r7,0x1234 (rs = r0)
    bus.id_ins = 32'h3C071234; rf_data1 = 32'hAAAA;
    step();
    chk_ex("lui", 1'b1, 32'h0, 32'h12340000, 8'h25, 3'b001, 1'b1, 5'd7, 1'b0);

    // no valid instruction -> bubble
    bus.id_valid = 1'b0;
    step();
    check("idle.valid", 64'(bus.ex_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
